uart_tx: RTL

Serial transmitter for the UART path. Consumes the 16x-oversampling `tick` from the baud-rate generator and a byte-wide parallel word with a start strobe. Shifts out a standard asynchronous frame, LSB first: start bit, DATA_BITS data bits, optional parity bit, stop period. Sits between the baud-rate generator and the `tx` pin, and provides a busy/done handshake to the upstream producer (FIFO or controller).

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 16x-tick driven frame serializer (start, LSB-first data, optional parity, stop).
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int S_W = (STOP_TICKS > 16) ? $clog2(STOP_TICKS) : 4;
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (STOP_TICKS < 16 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: STOP_TICKS must be >= 16 and PARITY_ODD 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic PODD = (PARITY_ODD != 0);
  logic parity_q, parity_d;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // A tick in the accepting cycle is deliberately not counted.
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^din) ^ PODD;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge as the state.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule
